// File: rtl/clock_period_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : clock_period_meter
// Description : Measures rise-to-rise period and rise-to-fall high time of a
//               slow asynchronous clock in in_clock cycles, with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
  parameter int          WIDTH   = 28,
  parameter int unsigned TIMEOUT = 28'd20000000
) (
  input  logic             in_clock,
  input  logic             reset_n,
  input  logic             meas_clock,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] c_timeout = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_WAIT_FIRST = 1'b0,
    ST_MEASURE    = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_rise;
  logic             w_fall;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hreg;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_hreg_nxt;
  logic [WIDTH-1:0] w_period_nxt;
  logic [WIDTH-1:0] w_high_time_nxt;
  logic             w_valid_nxt;
  logic             w_locked_nxt;
  logic             w_timeout_nxt;

  // s1/s2 resolve metastability; s3 is the previous synchronized level.
  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= meas_clock;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      r_state     <= ST_WAIT_FIRST;
      r_cnt       <= '0;
      r_hreg      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hreg      <= w_hreg_nxt;
      r_period    <= w_period_nxt;
      r_high_time <= w_high_time_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hreg_nxt      = r_hreg;
    w_period_nxt    = r_period;
    w_high_time_nxt = r_high_time;
    w_valid_nxt     = 1'b0;
    w_locked_nxt    = r_locked;
    w_timeout_nxt   = r_timeout;

    case (r_state)
      ST_WAIT_FIRST: begin
        if (w_rise) begin
          w_cnt_nxt   = c_one;
          w_hreg_nxt  = '0;
          w_state_nxt = ST_MEASURE;
        end else begin
          w_cnt_nxt = '0;
        end
      end

      ST_MEASURE: begin
        // A rise wins over a coincident timeout so a period of exactly
        // TIMEOUT cycles still reports.
        if (w_rise) begin
          w_period_nxt    = r_cnt;
          w_high_time_nxt = r_hreg;
          w_valid_nxt     = 1'b1;
          w_locked_nxt    = 1'b1;
          w_timeout_nxt   = 1'b0;
          w_cnt_nxt       = c_one;
          w_hreg_nxt      = '0;
        end else if (r_cnt == c_timeout) begin
          w_timeout_nxt = 1'b1;
          w_locked_nxt  = 1'b0;
          w_state_nxt   = ST_WAIT_FIRST;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
          if (w_fall) begin
            w_hreg_nxt = r_cnt;
          end
        end
      end

      default: begin
        w_state_nxt = ST_WAIT_FIRST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 Parameter WIDTH, default 28: bit width of the internal counter and of the period and high_time outputs.
REQ-002 Parameter TIMEOUT, default 28'd20000000: number of in_clock cycles after the last rising edge of meas_clock before a timeout is flagged; SHALL be ≤ 2^WIDTH-1.
REQ-003 in_clock  input  1  sole clock; all state updates on its posedge.
REQ-004 reset_n  input  1  synchronous, active-low reset; sampled on posedge in_clock.
REQ-005 meas_clock  input  1  slow clock under measurement, asynchronous to in_clock.
REQ-006 period  output  WIDTH  last measured rise-to-rise period, in in_clock cycles.
REQ-007 high_time  output  WIDTH  last measured rise-to-fall high time, in in_clock cycles.
REQ-008 valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 locked  output  1  level; at least one complete period measured since the last reset or timeout.
REQ-010 timeout  output  1  level; no rising edge of meas_clock seen within TIMEOUT cycles.

Function
REQ-011 meas_clock SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3.
- rise = s2 & ~s3
- fall = ~s2 & s3
REQ-012 FSM states SHALL be WAIT_FIRST and MEASURE; reset enters WAIT_FIRST.
REQ-013 WAIT_FIRST, on rise:
- cnt←1, hreg←0, go MEASURE
- no valid pulse
REQ-014 WAIT_FIRST, without rise: cnt SHALL hold 0.
REQ-015 MEASURE, each cycle without rise or timeout: cnt←cnt+1.
REQ-016 MEASURE, on fall: hreg←cnt, where cnt is the value in the fall cycle.
REQ-017 MEASURE, on rise (all in the next cycle):
- period←cnt, high_time←hreg
- valid=1 for exactly one cycle, locked←1, timeout←0
- cnt←1, hreg←0
REQ-018 Resulting semantics:
- period equals the exact number of in_clock cycles between successive detected rises.
- high_time equals the number of cycles from rise to fall.
- If no fall is detected between two rises, high_time SHALL be 0.
REQ-019 MEASURE, when cnt==TIMEOUT with no rise in that cycle (all in the next cycle):
- timeout←1, locked←0
- go WAIT_FIRST, cnt←0
- period and high_time hold their old values; no valid pulse
REQ-020 A rise in the same cycle as cnt==TIMEOUT SHALL be treated as a normal rise per REQ-017, with no timeout.
REQ-021 Since TIMEOUT ≤ 2^WIDTH-1, cnt SHALL never wrap; no saturation logic is required.
REQ-022 Detection latency SHALL be: a meas_clock edge meeting setup appears as rise/fall 2 in_clock cycles later; outputs update 1 cycle after that.
REQ-023 timeout SHALL remain set through WAIT_FIRST and clear only on the next valid pulse or on reset.

Reset
REQ-024 While reset_n=0 at a posedge, the following SHALL be 0 on the next cycle:
- s1, s2, s3, cnt, hreg
- period, high_time
- valid, locked, timeout
- state = WAIT_FIRST
REQ-025 Reset asserted mid-measurement SHALL discard the partial count; the first rise after release produces no valid (REQ-013).

Verification
REQ-026 Steady clock (TIMEOUT=100): meas_clock period 20 cycles, 50% duty, edges aligned to in_clock -> first rise gives no valid; every later rise gives valid with period=20, high_time=10; locked=1 after the first valid.
REQ-027 Asymmetric duty: high 3 / low 17 cycles -> period=20, high_time=3 on each valid.
REQ-028 Timeout (TIMEOUT=100): meas_clock stops low after a rise -> timeout=1 and locked=0 in the cycle after cnt reaches 100; period and high_time keep their last values; no valid pulse.
REQ-029 Recovery: restart meas_clock at period 30 after a timeout -> first rise gives no valid and timeout stays 1; second rise gives valid with period=30, and timeout drops to 0 in the same cycle.
REQ-030 Reset mid-measurement: reset_n=0 for 2 cycles halfway through a period -> all outputs 0; the first valid after release appears on the second rise following release, with the correct period.
REQ-031 Boundary: meas_clock period exactly 100 with TIMEOUT=100 -> rise coincides with cnt==100; valid with period=100; timeout stays 0.
